// File: rtl/echo_request_deserializer.sv
// Echo request deserializer: gathers one header beat plus payload beats into a
// single {tag, slot0, slot1, ...} message, holds it until the downstream pipe
// accepts it, and back-pressures the beat stream while the message is held.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   beat_enq__ENA/_v    incoming beat transfer / beat word
//   beat_enq__RDY       deserializer can accept a beat
//   pipe_enq__ENA/_v    outgoing message transfer / packed message
//   pipe_enq__RDY       downstream can accept a message
//   overflow_count      saturating count of messages longer than MAX_WORDS
module echo_request_deserializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 32,
    parameter int unsigned MAX_WORDS  = 2
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    beat_enq__ENA,
    input  logic [DATA_WIDTH-1:0]                   beat_enq_v,
    output logic                                    beat_enq__RDY,
    output logic                                    pipe_enq__ENA,
    output logic [TAG_WIDTH+MAX_WORDS*DATA_WIDTH-1:0] pipe_enq_v,
    input  logic                                    pipe_enq__RDY,
    output logic [15:0]                             overflow_count
);

    localparam int unsigned PAY_W = MAX_WORDS * DATA_WIDTH;
    localparam int unsigned VEC_W = TAG_WIDTH + PAY_W;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [VEC_W-1:0]   msg_q;
    logic [LEN_W-1:0]   rem_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   ovf_q;
    logic               beat_fire;

    // Header fields: tag in the upper half, payload length in the lower half.
    logic [15:0]        hdr_tag;
    logic [LEN_W-1:0]   hdr_len;

    assign hdr_tag = beat_enq_v[31:16];
    assign hdr_len = beat_enq_v[15:0];

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; RST masks both handshakes.
    always_comb begin
        state_d       = state_q;
        beat_enq__RDY = 1'b0;
        pipe_enq__ENA = 1'b0;
        beat_fire     = 1'b0;
        case (state_q)
            HDR: begin
                beat_enq__RDY = !RST;
                beat_fire     = beat_enq__ENA && !RST;
                if (beat_fire) begin
                    state_d = (hdr_len == '0) ? FULL : PAY;
                end
            end
            PAY: begin
                beat_enq__RDY = !RST;
                beat_fire     = beat_enq__ENA && !RST;
                if (beat_fire && rem_q == LEN_W'(1)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                pipe_enq__ENA = pipe_enq__RDY && !RST;
                if (pipe_enq__ENA) begin
                    state_d = HDR;
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    // Message assembly, payload bookkeeping and overflow counting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            msg_q <= '0;
            rem_q <= '0;
            idx_q <= '0;
            ovf_q <= '0;
        end else begin
            case (state_q)
                HDR: begin
                    if (beat_fire) begin
                        // New message: fresh tag, stale payload slots cleared.
                        msg_q <= {TAG_WIDTH'(hdr_tag), PAY_W'(0)};
                        rem_q <= hdr_len;
                        idx_q <= '0;
                        if (hdr_len > LEN_W'(MAX_WORDS) && ovf_q != '1) begin
                            ovf_q <= ovf_q + CNT_W'(1);
                        end
                    end
                end
                PAY: begin
                    if (beat_fire) begin
                        // Slot i sits just below the tag, descending with i;
                        // beats past the last slot are dropped.
                        for (int i = 0; i < int'(MAX_WORDS); i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                msg_q[(int'(MAX_WORDS) - i) * int'(DATA_WIDTH) - 1 -: DATA_WIDTH] <= beat_enq_v;
                            end
                        end
                        if (idx_q != IDX_W'(MAX_WORDS)) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                        rem_q <= rem_q - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pipe_enq_v     = msg_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_echo_request_deserializer.sv
// Self-checking bench for echo_request_deserializer: directed scenarios plus
// randomized messages checked against a message-level reference model.
module tb_echo_request_deserializer;

    logic        CLK;
    logic        RST;
    logic        beat_enq__ENA;
    logic [31:0] beat_enq_v;
    logic        beat_enq__RDY;
    logic        pipe_enq__ENA;
    logic [95:0] pipe_enq_v;
    logic        pipe_enq__RDY;
    logic [15:0] overflow_count;

    int          checks;
    int          errors;
    int          ena_pulses;
    logic [15:0] exp_ovf;

    echo_request_deserializer dut (
        .CLK            (CLK),
        .RST            (RST),
        .beat_enq__ENA  (beat_enq__ENA),
        .beat_enq_v     (beat_enq_v),
        .beat_enq__RDY  (beat_enq__RDY),
        .pipe_enq__ENA  (pipe_enq__ENA),
        .pipe_enq_v     (pipe_enq_v),
        .pipe_enq__RDY  (pipe_enq__RDY),
        .overflow_count (overflow_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count delivered messages; trace accepted beats.
    always @(posedge CLK) begin
        if (pipe_enq__ENA) ena_pulses++;
        if (beat_enq__ENA && beat_enq__RDY && !RST)
            $display("entered echo_request_deserializer::enq");
    end

    // Expected message: tag zero-extended, first two payload beats, rest zero.
    function automatic logic [95:0] model_vec(input logic [15:0] tag, input int len,
                                              input logic [31:0] beats[$]);
        logic [31:0] slot [2];
        slot[0] = 32'h0;
        slot[1] = 32'h0;
        for (int i = 0; i < len && i < 2; i++) slot[i] = beats[i];
        return {16'h0, tag, slot[0], slot[1]};
    endfunction

    // Send one message, optionally with idle gaps, then stall the pipe and release it.
    task automatic run_msg(input string name, input logic [15:0] tag, input int len,
                           input logic [31:0] beats[$], input int stall, input bit gaps);
        logic [95:0] exp;
        int          p0;
        exp = model_vec(tag, len, beats);
        if (len > 2 && exp_ovf != 16'hFFFF) exp_ovf++;
        pipe_enq__RDY = (stall == 0);
        @(negedge CLK);
        checks++;
        if (beat_enq__RDY !== 1'b1) begin
            errors++; $display("FAIL %s hdr_rdy: got %b want 1", name, beat_enq__RDY);
        end
        beat_enq__ENA = 1'b1;
        beat_enq_v    = {tag, 16'(len)};
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            if (gaps && $urandom_range(0, 3) == 0) begin
                beat_enq__ENA = 1'b0;
                beat_enq_v    = $urandom;
                @(negedge CLK);
            end
            checks++;
            if (beat_enq__RDY !== 1'b1) begin
                errors++; $display("FAIL %s pay_rdy[%0d]: got %b want 1", name, i, beat_enq__RDY);
            end
            beat_enq__ENA = 1'b1;
            beat_enq_v    = beats[i];
        end
        @(negedge CLK);
        beat_enq__ENA = 1'b0;
        beat_enq_v    = $urandom;
        p0 = ena_pulses;
        #1;
        checks++;
        if (pipe_enq_v !== exp) begin
            errors++; $display("FAIL %s vec: got %h want %h", name, pipe_enq_v, exp);
        end
        checks++;
        if (overflow_count !== exp_ovf) begin
            errors++; $display("FAIL %s ovf: got %0d want %0d", name, overflow_count, exp_ovf);
        end
        for (int s = 0; s < stall; s++) begin
            checks++;
            if (pipe_enq__ENA !== 1'b0 || beat_enq__RDY !== 1'b0 || pipe_enq_v !== exp) begin
                errors++;
                $display("FAIL %s stall[%0d]: ena=%b rdy=%b vec=%h want ena=0 rdy=0 vec=%h",
                         name, s, pipe_enq__ENA, beat_enq__RDY, pipe_enq_v, exp);
            end
            @(negedge CLK);
            #1;
        end
        pipe_enq__RDY = 1'b1;
        #1;
        checks++;
        if (pipe_enq__ENA !== 1'b1 || beat_enq__RDY !== 1'b0) begin
            errors++; $display("FAIL %s full_ena: ena=%b rdy=%b want ena=1 rdy=0",
                               name, pipe_enq__ENA, beat_enq__RDY);
        end
        @(negedge CLK);
        pipe_enq__RDY = 1'b0;
        #1;
        checks++;
        if (ena_pulses !== p0 + 1 || beat_enq__RDY !== 1'b1 || pipe_enq_v !== exp) begin
            errors++;
            $display("FAIL %s after: pulses=%0d rdy=%b vec=%h want pulses=%0d rdy=1 vec=%h",
                     name, ena_pulses - p0, beat_enq__RDY, pipe_enq_v, 1, exp);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        beat_enq__ENA = 1'b0;
        beat_enq_v    = 32'h0;
        pipe_enq__RDY = 1'b1;
        exp_ovf = 16'h0;
        repeat (2) @(negedge CLK);
        checks++;
        if (beat_enq__RDY !== 1'b0 || pipe_enq__ENA !== 1'b0 || pipe_enq_v !== 96'h0 ||
            overflow_count !== 16'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b ena=%b vec=%h ovf=%0d want all 0",
                     beat_enq__RDY, pipe_enq__ENA, pipe_enq_v, overflow_count);
        end
        RST = 1'b0;
        pipe_enq__RDY = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] b[$];
        b = '{32'h11, 32'h22};
        run_msg("basic", 16'h0001, 2, b, 0, 1'b0);
        checks++;
        if (pipe_enq_v !== 96'h1_00000011_00000022) begin
            errors++; $display("FAIL basic_const: got %h want %h", pipe_enq_v, 96'h1_00000011_00000022);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] b[$];
        b = '{32'h11, 32'h22};
        run_msg("backpressure", 16'h0001, 2, b, 5, 1'b0);
    endtask

    task automatic test_len_zero();
        logic [31:0] b[$];
        b = {};
        run_msg("len_zero", 16'h0003, 0, b, 1, 1'b0);
    endtask

    task automatic test_overflow();
        logic [31:0] b[$];
        b = '{32'hA, 32'hB, 32'hC, 32'hD};
        run_msg("overflow", 16'h0001, 4, b, 0, 1'b0);
        b = '{32'h1234, 32'h5678};
        run_msg("post_overflow", 16'h0002, 2, b, 0, 1'b0);
    endtask

    task automatic test_stale_slot();
        logic [31:0] b[$];
        b = '{32'h55};
        run_msg("stale_slot", 16'h0001, 1, b, 0, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [31:0] b[$];
        int          p0;
        @(negedge CLK);
        beat_enq__ENA = 1'b1;
        beat_enq_v    = 32'h0007_0002;
        @(negedge CLK);
        beat_enq_v    = 32'hAA;
        @(negedge CLK);
        beat_enq__ENA = 1'b0;
        pipe_enq__RDY = 1'b1;
        p0  = ena_pulses;
        RST = 1'b1;
        #1;
        checks++;
        if (beat_enq__RDY !== 1'b0 || pipe_enq__ENA !== 1'b0 || pipe_enq_v !== 96'h0 ||
            overflow_count !== 16'h0) begin
            errors++;
            $display("FAIL abort_rst: rdy=%b ena=%b vec=%h ovf=%0d want all 0",
                     beat_enq__RDY, pipe_enq__ENA, pipe_enq_v, overflow_count);
        end
        @(negedge CLK);
        RST = 1'b0;
        exp_ovf = 16'h0;
        repeat (3) @(negedge CLK);
        checks++;
        if (ena_pulses !== p0 || beat_enq__RDY !== 1'b1) begin
            errors++; $display("FAIL abort_idle: pulses=%0d rdy=%b want pulses=0 rdy=1",
                               ena_pulses - p0, beat_enq__RDY);
        end
        pipe_enq__RDY = 1'b0;
        b = '{32'hBEEF, 32'hCAFE};
        run_msg("after_abort", 16'h0009, 2, b, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] b[$];
        int          len;
        for (int m = 0; m < 40; m++) begin
            len = $urandom_range(0, 5);
            b = {};
            for (int i = 0; i < len; i++) b.push_back($urandom);
            run_msg("random", 16'($urandom), len, b, $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ena_pulses = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_len_zero();
        test_overflow();
        test_stale_slot();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
